pipe_scheduler: RTL and testbench

Sequencer for the pipe obstacles of the flappy-bird game. Owns the `N_PIPE` pipe-gap records that `view` draws: scrolls them left at a fixed cadence, respawns each pipe at the right edge with a pseudo-random gap once it leaves the screen, detects bird/pipe collision and keeps the score. It sits between `controller` (scene, bird altitude) and `view` (pipe drawing) and replaces the pipe-update logic inside `controller`.

---
 rtl/pipe_scheduler.sv | 125 ++++++++++++
 tb/tb_pipe_scheduler.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_scheduler.sv
// Pipe obstacle sequencer: scrolls N_PIPE gap records, respawns them with LFSR gaps, scores and detects collisions.
// Latency: all outputs registered; one scroll step every SCROLL_DIV run cycles, hit visible one edge after overlap.
// Backpressure: none; motion is gated by run and frozen by a sticky hit until rst.
module pipe_scheduler #(
  parameter int N_PIPE     = 3,
  parameter int SPACING    = 50,
  parameter int GAP        = 10,
  parameter int SCROLL_DIV = 3,
  parameter int HIT_LO     = 0,
  parameter int HIT_HI     = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  run,
  input  logic [7:0]            n_row,
  input  logic [7:0]            bird_alt,
  output logic [24*N_PIPE-1:0]  pipes,
  output logic [7:0]            score,
  output logic                  hit,
  output logic                  spawn
);

  localparam int          CW          = (SCROLL_DIV > 1) ? $clog2(SCROLL_DIV) : 1;
  localparam logic [CW-1:0] CNT_LAST  = CW'(SCROLL_DIV - 1);
  localparam logic [7:0]  RESPAWN_POS = 8'(N_PIPE * SPACING - 1);
  localparam logic [7:0]  GAP8        = 8'(GAP);
  localparam logic [7:0]  HIT_LO8     = 8'(HIT_LO);
  localparam logic [7:0]  HIT_SPAN8   = 8'(HIT_HI - HIT_LO);
  localparam logic [7:0]  INIT_LO     = 8'd20;

  logic [7:0]    pos_q [N_PIPE];
  logic [7:0]    lo_q  [N_PIPE];
  logic [7:0]    hi_q  [N_PIPE];
  logic [CW-1:0] cnt_q;
  logic [7:0]    lfsr_q;

  logic       collide;
  logic       any_zero;
  logic       advance;
  logic       tick;
  logic       respawn;
  logic [7:0] lo_raw;
  logic [7:0] row_lim;
  logic [7:0] resp_lo;

  // Collision check on registered pipes, plus scroll/respawn qualifiers and the clamped respawn gap.
  always_comb begin
    collide  = 1'b0;
    any_zero = 1'b0;
    for (int i = 0; i < N_PIPE; i++) begin
      // Window test as one unsigned subtract so a zero HIT_LO needs no special case.
      if (((pos_q[i] - HIT_LO8) <= HIT_SPAN8) &&
          ((bird_alt <= lo_q[i]) || (bird_alt >= hi_q[i]))) begin
        collide = 1'b1;
      end
      if (pos_q[i] == 8'd0) begin
        any_zero = 1'b1;
      end
    end
    collide = collide & run;
    // A collision in this cycle freezes everything, including the divider.
    advance = run & ~hit & ~collide;
    tick    = advance & (cnt_q == CNT_LAST);
    respawn = tick & any_zero;

    lo_raw  = {3'b000, lfsr_q[4:0]} + 8'd2;
    row_lim = n_row - 8'd2;
    resp_lo = lo_raw;
    if ((lo_raw + GAP8) > row_lim) begin
      resp_lo = row_lim - GAP8;
    end
  end

  // State update: reset values, divider, scroll/respawn, LFSR, score and sticky hit.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < N_PIPE; i++) begin
        pos_q[i] <= 8'(SPACING * (i + 1));
        lo_q[i]  <= INIT_LO;
        hi_q[i]  <= INIT_LO + GAP8;
      end
      cnt_q  <= '0;
      lfsr_q <= 8'hA5;
      score  <= 8'd0;
      hit    <= 1'b0;
      spawn  <= 1'b0;
    end else begin
      spawn <= 1'b0;
      if (collide) begin
        hit <= 1'b1;
      end
      if (advance) begin
        cnt_q <= tick ? '0 : cnt_q + 1'b1;
      end
      if (tick) begin
        for (int i = 0; i < N_PIPE; i++) begin
          if (pos_q[i] == 8'd0) begin
            pos_q[i] <= RESPAWN_POS;
            lo_q[i]  <= resp_lo;
            hi_q[i]  <= resp_lo + GAP8;
          end else begin
            pos_q[i] <= pos_q[i] - 8'd1;
          end
        end
      end
      // Spacing guarantees a single respawning slot, so the LFSR steps once per tick at most.
      if (respawn) begin
        lfsr_q <= {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
        spawn  <= 1'b1;
        if (score != 8'hFF) begin
          score <= score + 8'd1;
        end
      end
    end
  end

  // Pack slot records for the view: {position, max_bnd, min_bnd}.
  always_comb begin
    pipes = '0;
    for (int i = 0; i < N_PIPE; i++) begin
      pipes[24*i +: 24] = {pos_q[i], hi_q[i], lo_q[i]};
    end
  end

endmodule

// File: tb/tb_pipe_scheduler.sv
// Scoreboard bench for pipe_scheduler: stimulus queues expected snapshots and respawn records.
// A negedge monitor compares queued snapshots and pops a respawn record on every spawn pulse.
// Directed scenarios: reset, cadence with run gating, respawn/LFSR, clamp, collision freeze, reset mid-run.
module tb_pipe_scheduler;

  logic        clk;
  logic        rst;
  logic        run;
  logic [7:0]  n_row;
  logic [7:0]  bird_alt;
  logic [71:0] pipes;
  logic [7:0]  score;
  logic        hit;
  logic        spawn;

  typedef struct {
    logic [71:0] pipes;
    logic [7:0]  score;
    logic        hit;
    logic        spawn;
  } snap_t;

  typedef struct {
    int          slot;
    logic [23:0] rec;
    logic [7:0]  score;
  } spawn_t;

  snap_t  snap_q[$];
  string  snap_name_q[$];
  spawn_t spawn_q[$];
  string  spawn_name_q[$];

  int n_cmp  = 0;
  int n_fail = 0;

  pipe_scheduler dut (
    .clk      (clk),
    .rst      (rst),
    .run      (run),
    .n_row    (n_row),
    .bird_alt (bird_alt),
    .pipes    (pipes),
    .score    (score),
    .hit      (hit),
    .spawn    (spawn)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [71:0] pk(input logic [7:0] p0, h0, l0, p1, h1, l1, p2, h2, l2);
    return {p2, h2, l2, p1, h1, l1, p0, h0, l0};
  endfunction

  // Monitor: compare queued snapshots and every spawn pulse away from the active edge.
  always @(negedge clk) begin
    if (spawn) begin
      if (spawn_q.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL spawn_unexpected: got spawn=1 score=%0d, required no pulse", score);
      end else begin
        spawn_t e;
        string  nm;
        logic [23:0] got;
        e   = spawn_q.pop_front();
        nm  = spawn_name_q.pop_front();
        got = pipes[24*e.slot +: 24];
        n_cmp++;
        if (got !== e.rec) begin
          n_fail++;
          $display("FAIL %s rec: got %h required %h", nm, got, e.rec);
        end
        n_cmp++;
        if (score !== e.score) begin
          n_fail++;
          $display("FAIL %s score: got %0d required %0d", nm, score, e.score);
        end
      end
    end
    while (snap_q.size() > 0) begin
      snap_t s;
      string nm;
      s  = snap_q.pop_front();
      nm = snap_name_q.pop_front();
      n_cmp++;
      if (pipes !== s.pipes) begin
        n_fail++;
        $display("FAIL %s pipes: got %h required %h", nm, pipes, s.pipes);
      end
      n_cmp++;
      if (score !== s.score) begin
        n_fail++;
        $display("FAIL %s score: got %0d required %0d", nm, score, s.score);
      end
      n_cmp++;
      if (hit !== s.hit) begin
        n_fail++;
        $display("FAIL %s hit: got %b required %b", nm, hit, s.hit);
      end
      n_cmp++;
      if (spawn !== s.spawn) begin
        n_fail++;
        $display("FAIL %s spawn: got %b required %b", nm, spawn, s.spawn);
      end
    end
  end

  task automatic expect_snap(input string nm, input logic [71:0] p, input logic [7:0] sc,
                             input logic h, input logic sp);
    snap_t s;
    s.pipes = p;
    s.score = sc;
    s.hit   = h;
    s.spawn = sp;
    snap_q.push_back(s);
    snap_name_q.push_back(nm);
    @(negedge clk);
    #1;
  endtask

  task automatic expect_spawn(input string nm, input int slot, input logic [23:0] rec,
                              input logic [7:0] sc);
    spawn_t e;
    e.slot  = slot;
    e.rec   = rec;
    e.score = sc;
    spawn_q.push_back(e);
    spawn_name_q.push_back(nm);
  endtask

  // run high for exactly n rising edges, then low again.
  task automatic run_cycles(input int n);
    run = 1'b1;
    repeat (n) @(posedge clk);
    #1;
    run = 1'b0;
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    repeat (n) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  logic [71:0] reset_pipes;

  initial begin
    rst      = 1'b0;
    run      = 1'b0;
    n_row    = 8'd40;
    bird_alt = 8'd25;
    reset_pipes = pk(8'd50, 8'd30, 8'd20, 8'd100, 8'd30, 8'd20, 8'd150, 8'd30, 8'd20);
    #2;

    // Reset state.
    do_reset(2);
    expect_snap("reset", reset_pipes, 8'd0, 1'b0, 1'b0);

    // Cadence, with run gating preserving the divider.
    run_cycles(3);
    expect_snap("cadence_first", pk(8'd49, 8'd30, 8'd20, 8'd99, 8'd30, 8'd20, 8'd149, 8'd30, 8'd20),
                8'd0, 1'b0, 1'b0);
    run_cycles(2);
    repeat (5) @(posedge clk);
    #1;
    expect_snap("cadence_paused", pk(8'd49, 8'd30, 8'd20, 8'd99, 8'd30, 8'd20, 8'd149, 8'd30, 8'd20),
                8'd0, 1'b0, 1'b0);
    run_cycles(1);
    expect_snap("cadence_resume", pk(8'd48, 8'd30, 8'd20, 8'd98, 8'd30, 8'd20, 8'd148, 8'd30, 8'd20),
                8'd0, 1'b0, 1'b0);

    // Respawn of slot0 (lfsr A5 -> lo 7) and slot1 (lfsr 4A -> lo 12).
    do_reset(1);
    expect_spawn("spawn_slot0", 0, {8'd149, 8'd17, 8'd7}, 8'd1);
    run_cycles(153);
    expect_snap("respawn0", pk(8'd149, 8'd17, 8'd7, 8'd49, 8'd30, 8'd20, 8'd99, 8'd30, 8'd20),
                8'd1, 1'b0, 1'b1);
    run_cycles(1);
    expect_snap("respawn0_pulse_end", pk(8'd149, 8'd17, 8'd7, 8'd49, 8'd30, 8'd20, 8'd99, 8'd30, 8'd20),
                8'd1, 1'b0, 1'b0);
    expect_spawn("spawn_slot1", 1, {8'd149, 8'd22, 8'd12}, 8'd2);
    run_cycles(149);
    expect_snap("respawn1", pk(8'd99, 8'd17, 8'd7, 8'd149, 8'd22, 8'd12, 8'd49, 8'd30, 8'd20),
                8'd2, 1'b0, 1'b1);

    // Clamp against a short screen: lo 7 exceeds 16-2-10, so lo = 4.
    n_row = 8'd16;
    do_reset(1);
    expect_spawn("spawn_clamp", 0, {8'd149, 8'd14, 8'd4}, 8'd1);
    run_cycles(153);
    expect_snap("clamp", pk(8'd149, 8'd14, 8'd4, 8'd49, 8'd30, 8'd20, 8'd99, 8'd30, 8'd20),
                8'd1, 1'b0, 1'b1);

    // Collision: bird below the gap as slot0 enters the hit window at position 8.
    n_row    = 8'd40;
    bird_alt = 8'd5;
    do_reset(1);
    run_cycles(126);
    expect_snap("pre_hit", pk(8'd8, 8'd30, 8'd20, 8'd58, 8'd30, 8'd20, 8'd108, 8'd30, 8'd20),
                8'd0, 1'b0, 1'b0);
    run_cycles(1);
    expect_snap("hit_set", pk(8'd8, 8'd30, 8'd20, 8'd58, 8'd30, 8'd20, 8'd108, 8'd30, 8'd20),
                8'd0, 1'b1, 1'b0);
    run_cycles(20);
    expect_snap("hit_frozen", pk(8'd8, 8'd30, 8'd20, 8'd58, 8'd30, 8'd20, 8'd108, 8'd30, 8'd20),
                8'd0, 1'b1, 1'b0);

    // Reset while running and hit: everything back to reset values, scrolling resumes.
    run = 1'b1;
    do_reset(1);
    run = 1'b0;
    expect_snap("reset_mid_run", reset_pipes, 8'd0, 1'b0, 1'b0);
    run_cycles(3);
    expect_snap("resume_after_reset", pk(8'd49, 8'd30, 8'd20, 8'd99, 8'd30, 8'd20, 8'd149, 8'd30, 8'd20),
                8'd0, 1'b0, 1'b0);

    repeat (2) @(posedge clk);
    #1;
    if (spawn_q.size() != 0) begin
      n_cmp++;
      n_fail++;
      $display("FAIL spawn_missing: got %0d spawn pulses short, required 0", spawn_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
